// File: rtl/poly_collector_pkg.sv
// Shared HE types and collector state encoding used by poly_collector and neighbouring stages.
`ifndef BIT_WIDTH
`define BIT_WIDTH 24
`endif
`ifndef DEGREE_N
`define DEGREE_N 256
`endif

package poly_collector_pkg;

  localparam int BIT_WIDTH = `BIT_WIDTH;
  localparam int DEGREE_N  = `DEGREE_N;

  typedef logic [BIT_WIDTH-1:0] coeff_t;
  typedef coeff_t [DEGREE_N-1:0] poly_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_STALL = 2'd2
  } collector_state_t;

  // Occupancy of the ping-pong pair is fully described by the two full bits.
  function automatic collector_state_t state_of(input logic [1:0] full);
    case (full)
      2'b00:   return ST_EMPTY;
      2'b11:   return ST_STALL;
      default: return ST_ONE;
    endcase
  endfunction

endpackage

// File: rtl/poly_collector_if.sv
// Coefficient stream in, polynomial valid/ready out, plus sticky overflow and debug state.
interface poly_collector_if
  import poly_collector_pkg::*;
#(
  parameter int N = DEGREE_N,
  parameter int W = BIT_WIDTH
);
  // poly_o transfers on a cycle with poly_valid_o && poly_ready_i; once raised,
  // poly_valid_o and poly_o hold until that transfer. The coefficient stream has no backpressure.
  logic [W-1:0]          q;
  logic [W-1:0]          coeff_i;
  logic                  coeff_valid_i;
  logic [N-1:0][W-1:0]   poly_o;
  logic                  poly_valid_o;
  logic                  poly_ready_i;
  logic                  overflow_o;
  collector_state_t      state;

  modport slave (
    input  q, coeff_i, coeff_valid_i, poly_ready_i,
    output poly_o, poly_valid_o, overflow_o, state
  );

  modport master (
    output q, coeff_i, coeff_valid_i, poly_ready_i,
    input  poly_o, poly_valid_o, overflow_o, state
  );
endinterface

// File: rtl/poly_collector_mod_cond_sub.sv
// Single conditional subtraction: yields a mod q for a < 2q; q = 0 passes a through.
module mod_cond_sub #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] q,
  output logic [W-1:0] r
);
  assign r = (a >= q) ? a - q : a;
endmodule

// File: rtl/poly_collector.sv
// Reassembles a reduced coefficient stream into whole polynomials in a ping-pong buffer.
module poly_collector
  import poly_collector_pkg::*;
#(
  parameter int N = DEGREE_N,
  parameter int W = BIT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  poly_collector_if.slave bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef logic [W-1:0]  word_t;
  typedef word_t [N-1:0] vec_t;

  vec_t             bufs [2];
  logic [1:0]       full, full_n;
  logic             wr_sel, wr_sel_n;
  logic             rd_sel, rd_sel_n;
  logic [IDX_W-1:0] wr_idx, wr_idx_n;
  logic             overflow, overflow_n;

  word_t            r;
  logic             hs, wr_free, accept, drop, last;
  collector_state_t state;

  mod_cond_sub #(.W(W)) u_reduce (
    .a (bus.coeff_i),
    .q (bus.q),
    .r (r)
  );

  always_comb begin
    state   = state_of(full);
    hs      = full[rd_sel] && bus.poly_ready_i;
    // A full write buffer only frees up when it is also the one draining this cycle.
    wr_free = !full[wr_sel] || (hs && (rd_sel == wr_sel));
    accept  = bus.coeff_valid_i && wr_free;
    drop    = bus.coeff_valid_i && !wr_free;
    last    = (wr_idx == IDX_W'(N - 1));
  end

  always_comb begin
    full_n     = full;
    wr_sel_n   = wr_sel;
    rd_sel_n   = rd_sel;
    wr_idx_n   = wr_idx;
    overflow_n = overflow || drop;

    if (hs) begin
      full_n[rd_sel] = 1'b0;
      rd_sel_n       = ~rd_sel;
    end

    if (accept) begin
      if (last) begin
        full_n[wr_sel] = 1'b1;
        wr_idx_n       = '0;
        wr_sel_n       = ~wr_sel;
      end else begin
        wr_idx_n = wr_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      full     <= full_n;
      wr_sel   <= wr_sel_n;
      rd_sel   <= rd_sel_n;
      wr_idx   <= wr_idx_n;
      overflow <= overflow_n;
    end
  end

  // Storage has no reset; the gate on rst only keeps a reset cycle from writing.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      bufs[wr_sel][wr_idx] <= r;
    end
  end

  assign bus.poly_o       = bufs[rd_sel];
  assign bus.poly_valid_o = full[rd_sel];
  assign bus.overflow_o   = overflow;
  assign bus.state        = state;

endmodule
